// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared flag-interface constants: op classes and NZCV indices.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [1:0] OP_CLASS_ARITH   = 2'b00;
    localparam logic [1:0] OP_CLASS_LOGICAL = 2'b01;
    localparam logic [1:0] OP_CLASS_MUL     = 2'b10;
    localparam logic [1:0] OP_CLASS_MSR     = 2'b11;

    // Bit positions within {N,Z,C,V}, shared with the condition evaluator
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] nzcv_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/flag_compute.sv
`default_nettype none
// ============================================================================
// Module      : flag_compute
// Description : Combinational candidate-NZCV generator for one op class.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_compute
    import cpu_pkg::*;
#(
    parameter int RESULT_WIDTH = 32
) (
    input  logic [1:0]              op_class,
    input  logic [RESULT_WIDTH-1:0] result,
    input  logic                    alu_carry,
    input  logic                    alu_overflow,
    input  logic                    shifter_carry,
    input  logic [3:0]              msr_flags,
    input  logic [3:0]              cur_flags,
    output logic [3:0]              flags
);

    logic w_n;
    logic w_z;

    assign w_n = result[RESULT_WIDTH-1];
    assign w_z = ~|result;

    // Start from current flags so preserved bits fall through untouched
    always_comb begin
        flags = cur_flags;
        case (op_class)
            OP_CLASS_ARITH: begin
                flags[FLAG_N] = w_n;
                flags[FLAG_Z] = w_z;
                flags[FLAG_C] = alu_carry;
                flags[FLAG_V] = alu_overflow;
            end
            OP_CLASS_LOGICAL: begin
                flags[FLAG_N] = w_n;
                flags[FLAG_Z] = w_z;
                flags[FLAG_C] = shifter_carry;
            end
            OP_CLASS_MUL: begin
                flags[FLAG_N] = w_n;
                flags[FLAG_Z] = w_z;
            end
            default: begin
                flags = msr_flags;
            end
        endcase
    end

endmodule : flag_compute
`default_nettype wire

// File: rtl/cpsr_flag_register.sv
`default_nettype none
// ============================================================================
// Module      : cpsr_flag_register
// Description : Architectural NZCV flags, saved SPSR flags and next-flag bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module cpsr_flag_register
    import cpu_pkg::*;
#(
    parameter int RESULT_WIDTH = 32
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_valid,
    input  logic                    in_stall,
    input  logic                    in_execute_en,
    input  logic                    in_set_flags,
    input  logic [1:0]              in_op_class,
    input  logic [RESULT_WIDTH-1:0] in_result,
    input  logic                    in_alu_carry,
    input  logic                    in_alu_overflow,
    input  logic                    in_shifter_carry,
    input  logic [3:0]              in_msr_flags,
    input  logic                    in_exception,
    input  logic                    in_restore,
    output logic [3:0]              out_cpsr,
    output logic [3:0]              out_cpsr_next,
    output logic [3:0]              out_spsr,
    output logic                    out_flags_written
);

    nzcv_t r_cpsr;
    nzcv_t r_spsr;
    logic  r_flags_written;
    nzcv_t w_candidate;
    nzcv_t w_cpsr_next;
    logic  w_commit;
    logic  w_commit_applied;

    flag_compute #(
        .RESULT_WIDTH (RESULT_WIDTH)
    ) u_flag_compute (
        .op_class      (in_op_class),
        .result        (in_result),
        .alu_carry     (in_alu_carry),
        .alu_overflow  (in_alu_overflow),
        .shifter_carry (in_shifter_carry),
        .msr_flags     (in_msr_flags),
        .cur_flags     (r_cpsr),
        .flags         (w_candidate)
    );

    assign w_commit = in_valid & ~in_stall & in_execute_en
                    & (in_set_flags | (in_op_class == OP_CLASS_MSR));

    // Exception and restore both discard a same-cycle instruction commit
    assign w_commit_applied = w_commit & ~in_exception & ~in_restore;

    always_comb begin
        w_cpsr_next = r_cpsr;
        if (in_rst) begin
            w_cpsr_next = 4'b0000;
        end else if (in_exception) begin
            w_cpsr_next = r_cpsr;
        end else if (in_restore) begin
            w_cpsr_next = r_spsr;
        end else if (w_commit) begin
            w_cpsr_next = w_candidate;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_cpsr          <= 4'b0000;
            r_spsr          <= 4'b0000;
            r_flags_written <= 1'b0;
        end else begin
            r_cpsr          <= w_cpsr_next;
            r_flags_written <= w_commit_applied;
            if (in_exception) begin
                r_spsr <= r_cpsr;
            end
        end
    end

    assign out_cpsr          = r_cpsr;
    assign out_cpsr_next     = w_cpsr_next;
    assign out_spsr          = r_spsr;
    assign out_flags_written = r_flags_written;

endmodule : cpsr_flag_register
`default_nettype wire

// File: tb/tb_cpsr_flag_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpsr_flag_register
// Description : Directed vector table plus randomized reference-model checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpsr_flag_register;

    localparam int W = 32;

    logic         in_clk = 1'b0;
    logic         in_rst;
    logic         in_valid;
    logic         in_stall;
    logic         in_execute_en;
    logic         in_set_flags;
    logic [1:0]   in_op_class;
    logic [W-1:0] in_result;
    logic         in_alu_carry;
    logic         in_alu_overflow;
    logic         in_shifter_carry;
    logic [3:0]   in_msr_flags;
    logic         in_exception;
    logic         in_restore;
    logic [3:0]   out_cpsr;
    logic [3:0]   out_cpsr_next;
    logic [3:0]   out_spsr;
    logic         out_flags_written;

    int n_checks = 0;
    int n_pass   = 0;

    cpsr_flag_register #(.RESULT_WIDTH(W)) dut (
        .in_clk            (in_clk),
        .in_rst            (in_rst),
        .in_valid          (in_valid),
        .in_stall          (in_stall),
        .in_execute_en     (in_execute_en),
        .in_set_flags      (in_set_flags),
        .in_op_class       (in_op_class),
        .in_result         (in_result),
        .in_alu_carry      (in_alu_carry),
        .in_alu_overflow   (in_alu_overflow),
        .in_shifter_carry  (in_shifter_carry),
        .in_msr_flags      (in_msr_flags),
        .in_exception      (in_exception),
        .in_restore        (in_restore),
        .out_cpsr          (out_cpsr),
        .out_cpsr_next     (out_cpsr_next),
        .out_spsr          (out_spsr),
        .out_flags_written (out_flags_written)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic         valid;
        logic         stall;
        logic         exec;
        logic         s;
        logic [1:0]   op;
        logic [W-1:0] result;
        logic         ac;
        logic         ov;
        logic         sc;
        logic [3:0]   msr;
        logic         exc;
        logic         rest;
        logic [3:0]   e_next;
        logic [3:0]   e_cpsr;
        logic [3:0]   e_spsr;
        logic         e_fw;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic st, input logic ex, input logic s, input logic [1:0] op,
                                input logic [W-1:0] res, input logic ac, input logic ov, input logic sc,
                                input logic [3:0] msr, input logic exc, input logic rest,
                                input logic [3:0] en, input logic [3:0] ec, input logic [3:0] es,
                                input logic efw);
        vec_t v;
        v.valid = 1'b1; v.stall = st; v.exec = ex; v.s = s; v.op = op; v.result = res;
        v.ac = ac; v.ov = ov; v.sc = sc; v.msr = msr; v.exc = exc; v.rest = rest;
        v.e_next = en; v.e_cpsr = ec; v.e_spsr = es; v.e_fw = efw;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_valid = v.valid; in_stall = v.stall; in_execute_en = v.exec; in_set_flags = v.s;
        in_op_class = v.op; in_result = v.result; in_alu_carry = v.ac; in_alu_overflow = v.ov;
        in_shifter_carry = v.sc; in_msr_flags = v.msr; in_exception = v.exc; in_restore = v.rest;
    endtask

    // Reference model: flag semantics stated directly from the architectural rules
    logic [3:0] m_cpsr, m_spsr;
    logic       m_fw;

    function automatic logic [3:0] ref_next(input logic [3:0] cpsr, input logic [3:0] spsr);
        logic [3:0] cand;
        bit neg, zero, commit;
        neg  = (longint'(in_result) >= 64'h8000_0000);
        zero = (in_result == 0);
        commit = in_valid && !in_stall && in_execute_en && (in_set_flags || in_op_class == 2'd3);
        case (in_op_class)
            2'd0:    cand = {neg, zero, in_alu_carry, in_alu_overflow};
            2'd1:    cand = {neg, zero, in_shifter_carry, cpsr[0]};
            2'd2:    cand = {neg, zero, cpsr[1:0]};
            default: cand = in_msr_flags;
        endcase
        if (in_exception)    return cpsr;
        else if (in_restore) return spsr;
        else if (commit)     return cand;
        else                 return cpsr;
    endfunction

    function automatic logic ref_fw();
        return in_valid && !in_stall && in_execute_en && (in_set_flags || in_op_class == 2'd3)
               && !in_exception && !in_restore;
    endfunction

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 2'd0, '0, 0, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
        idle.valid = 1'b0;

        //            st ex s  op    result          ac ov sc msr    exc rs next    cpsr    spsr    fw
        tbl[0]  = mk(0, 1, 1, 2'd0, 32'h0,          1, 0, 0, 4'h0,  0, 0, 4'b0110, 4'b0110, 4'b0000, 1);
        tbl[1]  = mk(0, 1, 0, 2'd3, 32'h0,          0, 0, 0, 4'b0011,0,0, 4'b0011, 4'b0011, 4'b0000, 1);
        tbl[2]  = mk(0, 1, 1, 2'd1, 32'h8000_0000,  1, 0, 0, 4'h0,  0, 0, 4'b1001, 4'b1001, 4'b0000, 1);
        tbl[3]  = mk(0, 1, 1, 2'd2, 32'h5,          1, 1, 1, 4'h0,  0, 0, 4'b0001, 4'b0001, 4'b0000, 1);
        tbl[4]  = mk(0, 0, 1, 2'd0, 32'h0,          1, 0, 0, 4'h0,  0, 0, 4'b0001, 4'b0001, 4'b0000, 0);
        tbl[5]  = mk(0, 1, 0, 2'd0, 32'h0,          1, 0, 0, 4'h0,  0, 0, 4'b0001, 4'b0001, 4'b0000, 0);
        tbl[6]  = mk(1, 1, 1, 2'd0, 32'h0,          1, 0, 0, 4'h0,  0, 0, 4'b0001, 4'b0001, 4'b0000, 0);
        tbl[7]  = mk(0, 1, 0, 2'd3, 32'h0,          0, 0, 0, 4'b1010,0,0, 4'b1010, 4'b1010, 4'b0000, 1);
        tbl[8]  = mk(0, 1, 0, 2'd3, 32'h0,          0, 0, 0, 4'b0100,0,0, 4'b0100, 4'b0100, 4'b0000, 1);
        tbl[9]  = mk(0, 1, 1, 2'd3, 32'h0,          0, 0, 0, 4'b1000,1,0, 4'b0100, 4'b0100, 4'b0100, 0);
        tbl[10] = mk(0, 1, 1, 2'd3, 32'h0,          0, 0, 0, 4'b1111,0,0, 4'b1111, 4'b1111, 4'b0100, 1);
        tbl[11] = mk(1, 1, 1, 2'd3, 32'h0,          0, 0, 0, 4'b1000,0,1, 4'b0100, 4'b0100, 4'b0100, 0);
        tbl[12] = mk(0, 1, 1, 2'd3, 32'h0,          0, 0, 0, 4'b0010,0,0, 4'b0010, 4'b0010, 4'b0100, 1);
        tbl[13] = mk(0, 1, 1, 2'd3, 32'h0,          0, 0, 0, 4'b1111,1,1, 4'b0010, 4'b0010, 4'b0010, 0);
        tbl[14] = mk(0, 1, 1, 2'd3, 32'h0,          0, 0, 0, 4'b1000,0,0, 4'b1000, 4'b1000, 4'b0010, 1);
        tbl[15] = mk(0, 1, 1, 2'd3, 32'h0,          0, 0, 0, 4'b0100,0,0, 4'b0100, 4'b0100, 4'b0010, 1);
        tbl[16] = mk(0, 1, 1, 2'd3, 32'h0,          0, 0, 0, 4'b0010,0,0, 4'b0010, 4'b0010, 4'b0010, 1);
        tbl[17] = idle;
        tbl[17].e_next = 4'b0010; tbl[17].e_cpsr = 4'b0010; tbl[17].e_spsr = 4'b0010;

        // Reset with a pending MSR commit: bypass must still read zero
        in_rst = 1'b1;
        drive(mk(0, 1, 1, 2'd3, '0, 0, 0, 0, 4'b1111, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge in_clk);
        #1;
        chk("reset_next", out_cpsr_next, 4'b0000);
        chk("reset_cpsr", out_cpsr, 4'b0000);
        chk("reset_spsr", out_spsr, 4'b0000);
        chk("reset_fw", {3'b0, out_flags_written}, 4'b0000);
        drive(idle);
        #2 in_rst = 1'b0;
        @(posedge in_clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("tbl%0d_next", i), out_cpsr_next, tbl[i].e_next);
            @(posedge in_clk);
            #1;
            chk($sformatf("tbl%0d_cpsr", i), out_cpsr, tbl[i].e_cpsr);
            chk($sformatf("tbl%0d_spsr", i), out_spsr, tbl[i].e_spsr);
            chk($sformatf("tbl%0d_fw", i), {3'b0, out_flags_written}, {3'b0, tbl[i].e_fw});
        end

        // Mid-cycle asynchronous reset with CPSR=1111, SPSR and flags_written nonzero
        drive(mk(0, 1, 0, 2'd3, '0, 0, 0, 0, 4'b1111, 0, 0, 0, 0, 0, 0));
        @(posedge in_clk);
        #1;
        drive(idle);
        chk("pre_rst_cpsr", out_cpsr, 4'b1111);
        chk("pre_rst_fw", {3'b0, out_flags_written}, 4'b0001);
        #2 in_rst = 1'b1;
        #1;
        chk("async_rst_cpsr", out_cpsr, 4'b0000);
        chk("async_rst_spsr", out_spsr, 4'b0000);
        chk("async_rst_fw", {3'b0, out_flags_written}, 4'b0000);
        #1 in_rst = 1'b0;

        // Randomized run against the reference model
        m_cpsr = 4'b0000; m_spsr = 4'b0000; m_fw = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic [3:0] exp_next;
            logic       exp_fw;
            @(posedge in_clk);
            #1;
            chk($sformatf("rnd%0d_cpsr", c), out_cpsr, m_cpsr);
            chk($sformatf("rnd%0d_spsr", c), out_spsr, m_spsr);
            chk($sformatf("rnd%0d_fw", c), {3'b0, out_flags_written}, {3'b0, m_fw});
            in_valid         = ($urandom_range(3) != 0);
            in_stall         = ($urandom_range(4) == 0);
            in_execute_en    = ($urandom_range(3) != 0);
            in_set_flags     = $urandom_range(1);
            in_op_class      = 2'($urandom_range(3));
            in_result        = ($urandom_range(3) == 0) ? '0 : W'($urandom);
            in_alu_carry     = $urandom_range(1);
            in_alu_overflow  = $urandom_range(1);
            in_shifter_carry = $urandom_range(1);
            in_msr_flags     = 4'($urandom_range(15));
            in_exception     = ($urandom_range(9) == 0);
            in_restore       = ($urandom_range(7) == 0);
            #1;
            exp_next = ref_next(m_cpsr, m_spsr);
            exp_fw   = ref_fw();
            chk($sformatf("rnd%0d_next", c), out_cpsr_next, exp_next);
            if (in_exception) m_spsr = m_cpsr;
            m_cpsr = exp_next;
            m_fw   = exp_fw;
        end
        @(posedge in_clk);
        #1;
        chk("rnd_final_cpsr", out_cpsr, m_cpsr);
        chk("rnd_final_spsr", out_spsr, m_spsr);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_cpsr_flag_register
`default_nettype wire
